// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter that grants one register write per two clocks
// into a 4-entry bank, with the granted address/data held stable for the write.
module reg_write_arbiter #(
  parameter int size = 4
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [3:0]      Req,
  input  logic [1:0]      Addr0,
  input  logic [1:0]      Addr1,
  input  logic [1:0]      Addr2,
  input  logic [1:0]      Addr3,
  input  logic [size-1:0] Data0,
  input  logic [size-1:0] Data1,
  input  logic [size-1:0] Data2,
  input  logic [size-1:0] Data3,
  output logic [3:0]      Gnt,
  output logic [size-1:0] Reg0,
  output logic [size-1:0] Reg1,
  output logic [size-1:0] Reg2,
  output logic [size-1:0] Reg3,
  output logic            Busy,
  output logic [7:0]      WrCount
);
  typedef enum logic {IDLE, WRITE} state_t;
  state_t          state_q, state_d;
  logic [3:0]      gnt_q, gnt_d;
  logic [size-1:0] bank_q [4];
  logic [size-1:0] bank_d [4];
  logic [7:0]      cnt_q, cnt_d;
  logic [1:0]      last_q, last_d, addr_q, addr_d, win;
  logic [size-1:0] data_q, data_d;
  logic [1:0]      addr_in [4];
  logic [size-1:0] data_in [4];
  assign addr_in[0] = Addr0;
  assign addr_in[1] = Addr1;
  assign addr_in[2] = Addr2;
  assign addr_in[3] = Addr3;
  assign data_in[0] = Data0;
  assign data_in[1] = Data1;
  assign data_in[2] = Data2;
  assign data_in[3] = Data3;
  // Scan from farthest to nearest so the requester closest after last_q wins.
  always_comb begin
    win = last_q;
    for (int i = 3; i >= 0; i--)
      if (Req[last_q + 2'(i + 1)]) win = last_q + 2'(i + 1);
  end
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    bank_d  = bank_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (state_q == IDLE) begin
      if (|Req) begin
        state_d = WRITE;
        gnt_d   = 4'b0001 << win;
        last_d  = win;
        addr_d  = addr_in[win];
        data_d  = data_in[win];
      end
    end else begin
      bank_d[addr_q] = data_q;
      cnt_d          = cnt_q + 8'd1;
      gnt_d          = '0;
      state_d        = IDLE;
    end
  end
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      bank_q  <= '{default: '0};
      cnt_q   <= '0;
      last_q  <= 2'd3;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      bank_q  <= bank_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end
  assign Gnt     = gnt_q;
  assign Busy    = state_q == WRITE;
  assign WrCount = cnt_q;
  assign Reg0    = bank_q[0];
  assign Reg1    = bank_q[1];
  assign Reg2    = bank_q[2];
  assign Reg3    = bank_q[3];
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed stimulus pushes hand-computed grant/bank results into a
// queue; a negedge monitor pops one entry per grant and checks the bank after the write.
module tb_reg_write_arbiter;
  logic       Clk = 0, Rst = 1;
  logic [3:0] Req = 0;
  logic [1:0] Addr0 = 0, Addr1 = 0, Addr2 = 0, Addr3 = 0;
  logic [3:0] Data0 = 0, Data1 = 0, Data2 = 0, Data3 = 0;
  logic [3:0] Gnt, Reg0, Reg1, Reg2, Reg3;
  logic       Busy;
  logic [7:0] WrCount;
  int total = 0, bad = 0;
  typedef struct {
    logic [3:0] gnt;
    logic [3:0] r0, r1, r2, r3;
    logic [7:0] cnt;
  } exp_t;
  exp_t q[$];
  exp_t cur;
  bit pending = 0;
  reg_write_arbiter #(.size(4)) dut (
    .Clk(Clk), .Rst(Rst), .Req(Req),
    .Addr0(Addr0), .Addr1(Addr1), .Addr2(Addr2), .Addr3(Addr3),
    .Data0(Data0), .Data1(Data1), .Data2(Data2), .Data3(Data3),
    .Gnt(Gnt), .Reg0(Reg0), .Reg1(Reg1), .Reg2(Reg2), .Reg3(Reg3),
    .Busy(Busy), .WrCount(WrCount)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic push(input logic [3:0] g, input logic [3:0] r0, r1, r2, r3, input logic [7:0] c);
    exp_t e;
    e.gnt = g; e.r0 = r0; e.r1 = r1; e.r2 = r2; e.r3 = r3; e.cnt = c;
    q.push_back(e);
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, ".gnt"}, Gnt, 0);
    chk({tag, ".busy"}, Busy, 0);
    chk({tag, ".reg0"}, Reg0, 0);
    chk({tag, ".reg1"}, Reg1, 0);
    chk({tag, ".reg2"}, Reg2, 0);
    chk({tag, ".reg3"}, Reg3, 0);
    chk({tag, ".wrcount"}, WrCount, 0);
  endtask
  task automatic do_reset();
    Req = 0;
    @(posedge Clk);
    #2 Rst = 1;
    #1 chk_zero("reset");
    Rst = 0;
    tick(1);
  endtask
  // Monitor: a grant pops one expectation; the following negedge must show the completed write.
  initial forever begin
    @(negedge Clk);
    if (pending) begin
      pending = 0;
      chk("gnt_pulse_len", Gnt, 0);
      chk("busy_after_write", Busy, 0);
      chk("mon.reg0", Reg0, cur.r0);
      chk("mon.reg1", Reg1, cur.r1);
      chk("mon.reg2", Reg2, cur.r2);
      chk("mon.reg3", Reg3, cur.r3);
      chk("mon.wrcount", WrCount, cur.cnt);
    end else if (Gnt != 0) begin
      if (q.size() == 0) chk("unexpected_grant", Gnt, 0);
      else begin
        cur = q.pop_front();
        pending = 1;
        chk("mon.gnt", Gnt, cur.gnt);
        chk("busy_during_write", Busy, 1);
      end
    end
  end
  initial begin
    tick(2);
    chk_zero("init");
    Rst = 0;
    tick(1);
    // Single request from requester 0
    Addr0 = 2; Data0 = 4'hA;
    push(4'b0001, 0, 0, 4'hA, 0, 1);
    Req = 4'b0001;
    tick(1);
    Req = 0;
    tick(2);
    // All requesting for 8 clocks: strict rotation 0,1,2,3
    do_reset();
    Addr0 = 3; Data0 = 5; Addr1 = 2; Data1 = 6; Addr2 = 1; Data2 = 7; Addr3 = 0; Data3 = 8;
    push(4'b0001, 0, 0, 0, 5, 1);
    push(4'b0010, 0, 0, 6, 5, 2);
    push(4'b0100, 0, 7, 6, 5, 3);
    push(4'b1000, 8, 7, 6, 5, 4);
    Req = 4'b1111;
    tick(8);
    Req = 0;
    tick(2);
    // Same-target conflict: grant order decides, last write wins
    do_reset();
    Addr0 = 1; Data0 = 3; Addr1 = 1; Data1 = 5;
    push(4'b0001, 0, 3, 0, 0, 1);
    push(4'b0010, 0, 5, 0, 0, 2);
    Req = 4'b0011;
    tick(4);
    Req = 0;
    tick(1);
    // Inputs changed while busy must not alter the latched write
    Addr2 = 3; Data2 = 7;
    push(4'b0100, 0, 5, 0, 7, 3);
    Req = 4'b0100;
    tick(1);
    chk("busy_latch", Busy, 1);
    Addr2 = 0; Data2 = 4'hF; Req = 0;
    tick(2);
    // Reset in the middle of a write aborts it and restores requester 0 priority
    do_reset();
    Addr1 = 0; Data1 = 9;
    push(4'b0010, 9, 0, 0, 0, 1);
    Req = 4'b0010;
    tick(1);
    Req = 0;
    tick(1);
    Addr3 = 1; Data3 = 4'hC; Req = 4'b1000;
    tick(1);
    chk("abort.gnt", Gnt, 4'b1000);
    chk("abort.busy", Busy, 1);
    Req = 0;
    #1 Rst = 1;
    #1 chk_zero("abort");
    Rst = 0;
    #1;
    Addr0 = 2; Data0 = 2;
    push(4'b0001, 0, 0, 2, 0, 1);
    push(4'b0010, 9, 0, 2, 0, 2);
    Req = 4'b0011;
    tick(4);
    Req = 0;
    tick(2);
    // 256 writes wrap WrCount back to 0
    do_reset();
    Addr0 = 0; Data0 = 1;
    for (int i = 1; i <= 256; i++) push(4'b0001, 1, 0, 0, 0, 8'(i));
    Req = 4'b0001;
    tick(512);
    Req = 0;
    tick(3);
    chk("wrap.wrcount", WrCount, 0);
    chk("scoreboard_drained", q.size(), 0);
    chk("no_pending_write", pending, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
